// File: rtl/ldpc_pkg.sv
// Shared definitions for the 6-variable / 4-check LDPC decoder blocks.
package ldpc_pkg;

    localparam int N_VAR     = 6;
    localparam int N_CHK     = 4;
    localparam int LLR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Bit offset of lambda[idx] inside the packed lambda vector.
    function automatic int lambda_lsb(input int idx, input int llr_w);
        return idx * llr_w;
    endfunction

endpackage

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller: gathers one codeword of channel LLRs, launches
// decoder iterations until parity is met or the iteration budget runs out,
// then hands the hard decision to the downstream sink.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_LOAD  | accepting lambda samples 0..N_VAR-1 (o_rdy=1)
// ST_START | one-cycle o_start pulse, iteration count advances
// ST_WAIT  | iteration in flight, waiting for i_chk_val
// ST_OUT   | o_val=1, holding the decoded word until i_rdy
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int LLR_W    = LLR_W_DEF,
    parameter int N_VAR    = ldpc_pkg::N_VAR,
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 4
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic [LLR_W-1:0]         i_data,
    input  logic                     i_val,
    output logic                     o_rdy,
    output logic [N_VAR*LLR_W-1:0]   o_lambda,
    output logic                     o_start,
    input  logic [N_VAR-1:0]         i_est,
    input  logic                     i_parity,
    input  logic                     i_chk_val,
    output logic [N_VAR-1:0]         o_data,
    output logic                     o_val,
    input  logic                     i_rdy,
    output logic [ITER_W-1:0]        o_roop,
    output logic                     o_conv
);

    localparam int CNT_W = (N_VAR > 1) ? $clog2(N_VAR) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_VAR - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_SAT  = {ITER_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ITER_W-1:0] iter;

    logic              sample_we;
    logic              sample_last;
    logic              latch_out;
    logic              out_done;

    // State register.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the handshake/strobe outputs derived from state.
    always_comb begin
        state_nxt   = state;
        o_rdy       = 1'b0;
        o_start     = 1'b0;
        o_val       = 1'b0;
        sample_we   = 1'b0;
        sample_last = 1'b0;
        latch_out   = 1'b0;
        out_done    = 1'b0;
        case (state)
            ST_LOAD: begin
                o_rdy = 1'b1;
                if (i_val) begin
                    sample_we = 1'b1;
                    if (cnt == CNT_LAST) begin
                        sample_last = 1'b1;
                        state_nxt   = ST_START;
                    end
                end
            end
            ST_START: begin
                o_start   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_chk_val) begin
                    // Parity met or budget exhausted both end the word.
                    if (i_parity || (iter == ITER_MAX)) begin
                        latch_out = 1'b1;
                        state_nxt = ST_OUT;
                    end else begin
                        state_nxt = ST_START;
                    end
                end
            end
            ST_OUT: begin
                o_val = 1'b1;
                if (i_rdy) begin
                    out_done  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Sample counter and lambda buffer; lambda only moves while loading.
    always_ff @(posedge clk) begin
        if (xrst) begin
            cnt      <= '0;
            o_lambda <= '0;
        end else begin
            if (sample_we) begin
                for (int k = 0; k < N_VAR; k++) begin
                    if (int'(cnt) == k) begin
                        o_lambda[lambda_lsb(k, LLR_W) +: LLR_W] <= i_data;
                    end
                end
                cnt <= sample_last ? '0 : cnt + 1'b1;
            end else if (out_done) begin
                cnt <= '0;
            end
        end
    end

    // Iteration counter: cleared when a fresh word is complete, bumped per launch.
    always_ff @(posedge clk) begin
        if (xrst) begin
            iter <= '0;
        end else if (sample_last) begin
            iter <= '0;
        end else if (o_start && (iter != ITER_SAT)) begin
            iter <= iter + 1'b1;
        end
    end

    // Result registers hold the last word's outcome until the next word finishes.
    always_ff @(posedge clk) begin
        if (xrst) begin
            o_data <= '0;
            o_roop <= '0;
            o_conv <= 1'b0;
        end else if (latch_out) begin
            o_data <= i_est;
            o_roop <= iter;
            o_conv <= i_parity;
        end
    end

endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
Iteration controller for the 6-bit / 4-check LDPC decoder. It collects one codeword of channel LLRs (lambda) from a serial input stream and launches message-passing iterations. After each iteration it consumes the hard-decision estimate and parity flag from the parity/estimate stage, then either starts another iteration or emits the decoded word. It sits between the channel LLR source and the downstream data sink, wrapping the alpha/beta update and parity stages.

Parameters:
LLR_W, 8, signed LLR width of each lambda sample
N_VAR, 6, codeword length (fixed by the H matrix; not intended to be changed)
MAX_ITER, 10, maximum iterations per codeword; legal range 1..(2^ITER_W - 1)
ITER_W, 4, width of the iteration counter / o_roop

Ports:
clk  in  1  single clock, rising edge
xrst  in  1  synchronous reset, active-high
i_data  in  LLR_W  signed channel LLR sample
i_val  in  1  i_data valid
o_rdy  out  1  controller accepts i_data this cycle
o_lambda  out  N_VAR*LLR_W  packed lambda; lambda[k] at bits [k*LLR_W +: LLR_W]
o_start  out  1  one-cycle pulse: begin one decoder iteration
i_est  in  N_VAR  hard-decision estimate, bit k = estimate[k]
i_parity  in  1  1 = all four checks satisfied
i_chk_val  in  1  i_est/i_parity valid (iteration finished)
o_data  out  N_VAR  decoded codeword
o_val  out  1  o_data valid
i_rdy  in  1  downstream accepts o_data
o_roop  out  ITER_W  iterations used for the current/last word
o_conv  out  1  1 = word converged (parity met); 0 = MAX_ITER exhausted

Behaviour:
- Reset: synchronous. While xrst=1 on a clock edge: state=LOAD, sample count=0, iteration count=0, o_lambda=0, o_start=0, o_data=0, o_val=0, o_roop=0, o_conv=0. o_rdy=1 in the first cycle after reset. A reset mid-operation abandons the word with no output.
- States: LOAD, START, WAIT, OUT.
- LOAD: o_rdy=1. Each cycle with i_val=1 writes i_data to lambda[cnt] in order cnt=0..5. On the 6th accepted sample (cnt=5) go to START and clear the iteration count. i_val is ignored in every other state, where o_rdy=0.
- START: o_start=1 for exactly this one cycle. The iteration count increments (count saturates, but MAX_ITER bounds it). Next state is WAIT.
- WAIT: hold o_lambda stable. On i_chk_val=1:
  - if i_parity=1: latch o_data=i_est, o_conv=1, o_roop=count, go to OUT;
  - else if count==MAX_ITER: latch o_data=i_est, o_conv=0, o_roop=count, go to OUT;
  - else go to START.
  i_chk_val outside WAIT is ignored.
- OUT: o_val=1. o_data, o_conv and o_roop are held until i_rdy=1. On an o_val&&i_rdy handshake go to LOAD with cnt=0; o_val falls on the next cycle. o_roop/o_conv keep their values until the next word latches them.
- Latency, assuming i_chk_val arrives L cycles after o_start: first o_start occurs 1 cycle after the 6th sample; each non-final iteration costs L+1 cycles; o_val rises 1 cycle after the final i_chk_val.
- No input pipelining: input is blocked while a word is in flight (one word at a time).
- o_lambda is registered; it changes only in LOAD.

Decomposition:
- Shared package ldpc_pkg: N_VAR=6, N_CHK=4, LLR_W default, state encoding (LOAD/START/WAIT/OUT), and the lambda packing/index helper.
- The controller is a single module, with no sub-module needed. The 6-entry lambda buffer is inline; optionally it becomes ldpc_llr_buf (serial-in, parallel-out shift buffer with count) if reused by the alpha-init stage.

Test Plan:
- Load and immediate convergence: after reset, send LLRs 10,-3,7,-128,127,0. Check o_lambda = {0,127,-128,7,-3,10} (lambda[5]..lambda[0]) and that one o_start pulse occurs. Respond with i_chk_val, i_parity=1, i_est=6'b000000 after 3 cycles. Expect o_val=1, o_data=0, o_roop=1, o_conv=1.
- Convergence on 3rd iteration: the model returns parity=0 twice, then parity=1 with i_est=6'b101010. Expect exactly 3 o_start pulses, o_data=6'b101010, o_roop=3, o_conv=1.
- Exhaustion: parity is always 0 and MAX_ITER=10. Expect 10 o_start pulses, o_roop=10, o_conv=0, and o_data equal to the last i_est.
- Backpressure and blocking: hold i_rdy=0 for 5 cycles in OUT. o_data/o_val stay stable and o_rdy=0; i_val pulses are ignored (o_lambda unchanged). After i_rdy=1, the next word loads normally.
- Spurious strobes: i_chk_val during LOAD, and i_val during WAIT, cause no state change, no o_start and no lambda write.
- Reset mid-iteration: assert xrst in WAIT after 2 iterations. The next cycle shows all outputs 0, o_rdy=1, and no o_val; a fresh 6-sample load then decodes correctly with o_roop counting from 1.
